// File: rtl/line_window_pkg.sv
// Shared types and helpers for the line window buffer.
package line_window_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_STREAM,
        S_DONE
    } state_e;

    // Counter width for a counter covering 0..x-1, never narrower than one bit.
    function automatic int cnt_w(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Line memory that feeds column slot `slot` given the current write selector.
    function automatic int slot_mem(input int wr_sel, input int slot, input int num_mem);
        return (wr_sel + slot) % num_mem;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of storage: asynchronous read, synchronous write.
module line_ram
    import line_window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5,
    parameter int ADDR_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read is combinational so the old pixel is visible in the same cycle it is overwritten.
    assign rdata = mem[addr];

    // Write the accepted pixel at the current column.
    // NOTE: the array has no reset; every location is written during the fill rows
    // before it is ever read into a valid column, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps sequential state update order-independent.
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Streams raster pixels in and emits one vertical NUM_ROWS-pixel column per
// accepted pixel once enough line history exists; re-arms after each frame.
module line_window_buffer
    import line_window_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 5,
    parameter int IMG_H    = 5,
    parameter int NUM_ROWS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_valid,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       idle,
    output logic [NUM_ROWS*DATA_W-1:0] col_data_o,
    output logic                       col_valid_o,
    input  logic                       out_ready,
    output logic                       ready,
    output logic                       done
);

    localparam int NUM_MEM = NUM_ROWS - 1;
    localparam int COL_W   = cnt_w(IMG_W);
    localparam int ROW_W   = cnt_w(IMG_H);
    localparam int SEL_W   = cnt_w(NUM_MEM);

    localparam logic [COL_W-1:0] COL_LAST       = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST  = ROW_W'(NUM_ROWS - 2);
    localparam logic [ROW_W-1:0] ROW_FIRST_COL  = ROW_W'(NUM_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST       = ROW_W'(IMG_H - 1);
    localparam logic [SEL_W-1:0] SEL_LAST       = SEL_W'(NUM_MEM - 1);

    state_e                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [SEL_W-1:0]          wr_sel_q, wr_sel_d;
    logic [NUM_ROWS*DATA_W-1:0] col_data_q, col_data_d;
    logic                      col_valid_q, col_valid_d;

    logic                      accept;
    logic                      consume;
    logic                      col_last;
    logic                      frame_done;
    logic [DATA_W-1:0]         rd_data [NUM_MEM];
    logic [NUM_MEM-1:0]        we;

    // Input is refused while draining the last column or while the output is blocked.
    assign idle     = !rst && (state_q != S_DONE) && (!col_valid_q || out_ready);
    assign accept   = data_valid && idle;
    assign consume  = col_valid_q && out_ready;
    assign col_last = (col_q == COL_LAST);

    assign col_data_o  = col_data_q;
    assign col_valid_o = col_valid_q;
    assign ready       = !rst && (state_q == S_STREAM);
    assign done        = !rst && frame_done;

    // Line memories rotate: the one selected by wr_sel holds the oldest line and is overwritten.
    for (genvar m = 0; m < NUM_MEM; m++) begin : g_mem
        assign we[m] = accept && (wr_sel_q == SEL_W'(m));

        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W),
            .ADDR_W (COL_W)
        ) u_ram (
            .clk   (clk),
            .we    (we[m]),
            .addr  (col_q),
            .wdata (data_i),
            .rdata (rd_data[m])
        );
    end

    // Column register: assemble oldest-to-newest on accept, hold until consumed.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        col_data_d  = col_data_q;
        col_valid_d = col_valid_q;
        if (consume) begin
            col_valid_d = 1'b0;
        end
        if (accept && (row_q >= ROW_FIRST_COL)) begin
            col_valid_d = 1'b1;
            for (int k = 0; k < NUM_MEM; k++) begin
                for (int m = 0; m < NUM_MEM; m++) begin
                    if (slot_mem(int'(wr_sel_q), k, NUM_MEM) == m) begin
                        col_data_d[k*DATA_W +: DATA_W] = rd_data[m];
                    end
                end
            end
            col_data_d[NUM_MEM*DATA_W +: DATA_W] = data_i;
        end
    end

    // Frame FSM and raster counters: next state, counter advance and end-of-frame re-arm.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        wr_sel_d   = wr_sel_q;
        frame_done = 1'b0;

        if (accept) begin
            if (col_last) begin
                col_d    = '0;
                row_d    = row_q + ROW_W'(1);
                wr_sel_d = (wr_sel_q == SEL_LAST) ? '0 : wr_sel_q + SEL_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        case (state_q)
            S_FILL: begin
                if (accept && col_last && (row_q == ROW_FILL_LAST)) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept && col_last && (row_q == ROW_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!col_valid_q) begin
                    frame_done = 1'b1;
                    col_d      = '0;
                    row_d      = '0;
                    wr_sel_d   = '0;
                    state_d    = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            col_q       <= '0;
            row_q       <= '0;
            wr_sel_q    <= '0;
            col_data_q  <= '0;
            col_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            wr_sel_q    <= wr_sel_d;
            col_data_q  <= col_data_d;
            col_valid_q <= col_valid_d;
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: default configuration (A) and a
// 10-bit, 8x6, 5-row configuration (B).
module tb_line_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_dv, a_idle, a_cv, a_or, a_ready, a_done;
    logic [7:0]  a_di;
    logic [23:0] a_col;

    logic        b_dv, b_idle, b_cv, b_or, b_ready, b_done;
    logic [9:0]  b_di;
    logic [49:0] b_col;

    line_window_buffer dut_a (
        .clk         (clk),
        .rst         (rst),
        .data_valid  (a_dv),
        .data_i      (a_di),
        .idle        (a_idle),
        .col_data_o  (a_col),
        .col_valid_o (a_cv),
        .out_ready   (a_or),
        .ready       (a_ready),
        .done        (a_done)
    );

    line_window_buffer #(
        .DATA_W   (10),
        .IMG_W    (8),
        .IMG_H    (6),
        .NUM_ROWS (5)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .data_valid  (b_dv),
        .data_i      (b_di),
        .idle        (b_idle),
        .col_data_o  (b_col),
        .col_valid_o (b_cv),
        .out_ready   (b_or),
        .ready       (b_ready),
        .done        (b_done)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] qa[$], qb[$];
    logic [63:0] a_log[$], b_log[$];
    int a_dones = 0, b_dones = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected column for pixel idx of a frame whose pixel value is base+idx.
    function automatic logic [63:0] exp_col(input int base, input int idx, input int w,
                                            input int nr, input int dw);
        int r;
        int c;
        logic [63:0] v;
        r = idx / w;
        c = idx % w;
        v = '0;
        for (int k = 0; k < nr; k++) begin
            v = v | (64'(base + (r - nr + 1 + k) * w + c) << (k * dw));
        end
        return v;
    endfunction

    // Monitor A: pop and compare on every handshake, check hold under backpressure.
    logic [23:0] a_prev_col;
    logic        a_prev_stall = 1'b0;
    always @(negedge clk) begin
        if (a_cv === 1'b1 && a_or === 1'b0) begin
            check("a_stall_idle", 64'(a_idle), 64'(0));
            if (a_prev_stall) check("a_stall_hold", 64'(a_col), 64'(a_prev_col));
        end
        a_prev_stall = (a_cv === 1'b1) && (a_or === 1'b0);
        a_prev_col   = a_col;
        if (a_cv === 1'b1 && a_or === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_col: got %0h expected no column", a_col);
            end else begin
                check("a_col", 64'(a_col), qa.pop_front());
            end
            a_log.push_back(64'(a_col));
        end
        if (a_done === 1'b1) a_dones++;
    end

    // Monitor B: same scoreboard discipline for the wide configuration.
    always @(negedge clk) begin
        if (b_cv === 1'b1 && b_or === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_col: got %0h expected no column", b_col);
            end else begin
                check("b_col", 64'(b_col), qb.pop_front());
            end
            b_log.push_back(64'(b_col));
        end
        if (b_done === 1'b1) b_dones++;
    end

    // Offer one pixel and wait (bounded) until it is accepted; push its expected column.
    task automatic drive(input int sel, input int base, input int idx);
        int  w;
        int  nr;
        int  dw;
        bit  ok;
        w  = (sel == 0) ? 5 : 8;
        nr = (sel == 0) ? 3 : 5;
        dw = (sel == 0) ? 8 : 10;
        if (sel == 0) begin
            a_dv = 1'b1;
            a_di = 8'(base + idx);
        end else begin
            b_dv = 1'b1;
            b_di = 10'(base + idx);
        end
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if ((sel == 0) ? a_idle : b_idle) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut=%0d idx=%0d: got idle=0 expected idle=1", sel, idx);
        end else if (idx / w >= nr - 1) begin
            if (sel == 0) qa.push_back(exp_col(base, idx, w, nr, dw));
            else          qb.push_back(exp_col(base, idx, w, nr, dw));
        end
        @(posedge clk);
        #1;
        a_dv = 1'b0;
        b_dv = 1'b0;
    endtask

    task automatic run_frame(input int sel, input int base, input bit gaps, input bit chk_ready);
        int n;
        n = (sel == 0) ? 25 : 48;
        for (int idx = 0; idx < n; idx++) begin
            drive(sel, base, idx);
            if (gaps) begin
                @(negedge clk);
                if (chk_ready) check("a_ready", 64'(a_ready), 64'(idx >= 9 && idx <= 23));
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Wait (bounded) for the done pulse, then confirm it lasts one cycle and input re-opens.
    task automatic finish_frame(input int sel);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if ((sel == 0) ? a_done : b_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", 64'((sel == 0) ? a_done : b_done), 64'(0));
        check("idle_after_done", 64'((sel == 0) ? a_idle : b_idle), 64'(1));
        check("queue_drained", 64'((sel == 0) ? qa.size() : qb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame_a(input int ncols, input int ndone, input int d0);
        check("a_col_count", 64'(a_log.size()), 64'(ncols));
        check("a_first_col", a_log[0], 64'(24'h0A0500));
        check("a_last_col", a_log[a_log.size() - 1], 64'(24'h18130E));
        check("a_done_count", 64'(a_dones - d0), 64'(ndone));
    endtask

    logic [49:0] e_wide;
    int          d0;

    initial begin
        rst  = 1'b1;
        a_dv = 1'b0;  a_di = '0;  a_or = 1'b1;
        b_dv = 1'b0;  b_di = '0;  b_or = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_idle", 64'(a_idle), 64'(0));
        check("rst_valid", 64'(a_cv), 64'(0));
        check("rst_col", 64'(a_col), 64'(0));
        check("rst_ready", 64'(a_ready), 64'(0));
        check("rst_done", 64'(a_done), 64'(0));
        check("rst_b_valid", 64'(b_cv), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 64'(a_idle), 64'(1));
        @(posedge clk);
        #1;

        // Plain stream, full throughput.
        a_log.delete();
        d0 = a_dones;
        run_frame(0, 0, 1'b0, 1'b0);
        finish_frame(0);
        check_frame_a(15, 1, d0);

        // Output stalled for four cycles mid-stream.
        a_log.delete();
        d0 = a_dones;
        fork
            run_frame(0, 0, 1'b0, 1'b0);
            begin
                repeat (13) @(posedge clk);
                #1;
                a_or = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                a_or = 1'b1;
            end
        join
        finish_frame(0);
        check_frame_a(15, 1, d0);

        // Input gaps every other cycle, ready tracked per accept.
        a_log.delete();
        d0 = a_dones;
        run_frame(0, 0, 1'b1, 1'b1);
        finish_frame(0);
        check_frame_a(15, 1, d0);

        // Reset mid-frame after pixel 0x0C, then a fresh frame.
        for (int idx = 0; idx <= 12; idx++) drive(0, 0, idx);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_idle", 64'(a_idle), 64'(0));
        check("midrst_valid", 64'(a_cv), 64'(0));
        check("midrst_col", 64'(a_col), 64'(0));
        check("midrst_ready", 64'(a_ready), 64'(0));
        check("midrst_done", 64'(a_done), 64'(0));
        check("midrst_queue", 64'(qa.size()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_log.delete();
        d0 = a_dones;
        run_frame(0, 0, 1'b0, 1'b0);
        finish_frame(0);
        check_frame_a(15, 1, d0);

        // Two frames back to back, second offset by 0x40.
        a_log.delete();
        d0 = a_dones;
        run_frame(0, 0, 1'b0, 1'b0);
        run_frame(0, 'h40, 1'b0, 1'b0);
        finish_frame(0);
        check("b2b_col_count", 64'(a_log.size()), 64'(30));
        check("b2b_f2_first", a_log[15], 64'(24'h4A4540));
        check("b2b_f2_last", a_log[29], 64'(24'h58534E));
        check("b2b_done_count", 64'(a_dones - d0), 64'(2));

        // Wide configuration, two frames to exercise wr_sel rotation and clearing.
        b_log.delete();
        d0 = b_dones;
        run_frame(1, 0, 1'b0, 1'b0);
        run_frame(1, 'h100, 1'b0, 1'b0);
        finish_frame(1);
        check("b_col_count", 64'(b_log.size()), 64'(32));
        e_wide = {10'd32, 10'd24, 10'd16, 10'd8, 10'd0};
        check("b_first_col", b_log[0], 64'(e_wide));
        e_wide = {10'd47, 10'd39, 10'd31, 10'd23, 10'd15};
        check("b_last_col", b_log[15], 64'(e_wide));
        e_wide = {10'h120, 10'h118, 10'h110, 10'h108, 10'h100};
        check("b_f2_first_col", b_log[16], 64'(e_wide));
        check("b_done_count", 64'(b_dones - d0), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
